// File: rtl/inst_rom_resp_pkg.sv
// rtl/inst_rom_resp_pkg.sv - shared widths, constants and FSM state type for the instruction ROM responder
package inst_rom_resp_pkg;
  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;
  localparam logic [InstBus-1:0] ZeroWord = 32'h0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/inst_rom_array.sv
// rtl/inst_rom_array.sv - DEPTHx32 synchronous-read word array, one write port, read-before-write
module inst_rom_array
  import inst_rom_resp_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [InstBus-1:0]       wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [InstBus-1:0]       rdata
);
  logic [InstBus-1:0] mem [DEPTH];

  // Both updates are non-blocking, so a same-edge read of the written index sees the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/inst_rom_resp.sv
// rtl/inst_rom_resp.sv - fetch responder: accept, wait states, registered response; optional misaligned-pc check under INST_ROM_MISALIGN_CHK_EN
module inst_rom_resp
  import inst_rom_resp_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ce,
  input  logic [InstAddrBus-1:0]   pc,
  output logic                     stall,
  output logic [InstBus-1:0]       inst,
  output logic [InstAddrBus-1:0]   inst_addr,
  output logic                     inst_valid,
  output logic                     inst_err,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [InstBus-1:0]       wdata
);
  localparam int AW = $clog2(DEPTH);

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [InstAddrBus-1:0] pc_q;
  logic                   err_q, err_now, accept, rd_en;
  logic [AW-1:0]          rd_idx;
  logic [InstBus-1:0]     rdata;

  always_comb begin
    err_now = (pc >> (AW + 2)) != '0;
`ifdef INST_ROM_MISALIGN_CHK_EN
    err_now = err_now | (pc[1:0] != 2'b00);
`endif
  end

  assign stall  = (state_q == WAIT);
  assign accept = ce & ~stall;

  // The array is read on the edge entering RESP so its output is ready for the response register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_en   = 1'b0;
    rd_idx  = pc[AW+1:2];
    case (state_q)
      WAIT: begin
        cnt_d  = cnt_q - 4'd1;
        rd_idx = pc_q[AW+1:2];
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          rd_en   = ~err_q;
        end
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          cnt_d = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
          end else begin
            state_d = RESP;
            rd_en   = ~err_now;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pc_q       <= '0;
      err_q      <= 1'b0;
      inst       <= ZeroWord;
      inst_addr  <= '0;
      inst_valid <= 1'b0;
      inst_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inst_valid <= (state_q == RESP);
      if (accept) begin
        pc_q  <= pc;
        err_q <= err_now;
      end
      if (state_q == RESP) begin
        inst      <= err_q ? ZeroWord : rdata;
        inst_addr <= pc_q;
        inst_err  <= err_q;
      end
    end
  end

  inst_rom_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (rd_en),
    .raddr (rd_idx),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_inst_rom_resp.sv
// tb/tb_inst_rom_resp.sv - directed self-checking bench for inst_rom_resp with 0, 3 and 5 wait states
module tb_inst_rom_resp;
  logic        clk = 1'b0;
  logic        rst, we;
  logic [9:0]  waddr;
  logic [31:0] wdata, pc;
  logic        ce0, ce3, ce5;
  logic        stall0, stall3, stall5;
  logic [31:0] inst0, inst3, inst5, addr0, addr3, addr5;
  logic        valid0, valid3, valid5, err0, err3, err5;
  int          total = 0;
  int          bad = 0;
  int          seen;

  always #5 clk = ~clk;

  inst_rom_resp #(.DEPTH(1024), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .ce(ce0), .pc(pc), .stall(stall0), .inst(inst0), .inst_addr(addr0),
    .inst_valid(valid0), .inst_err(err0), .we(we), .waddr(waddr), .wdata(wdata));
  inst_rom_resp #(.DEPTH(1024), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .ce(ce3), .pc(pc), .stall(stall3), .inst(inst3), .inst_addr(addr3),
    .inst_valid(valid3), .inst_err(err3), .we(we), .waddr(waddr), .wdata(wdata));
  inst_rom_resp #(.DEPTH(1024), .WAIT_CYCLES(5)) u5 (
    .clk(clk), .rst(rst), .ce(ce5), .pc(pc), .stall(stall5), .inst(inst5), .inst_addr(addr5),
    .inst_valid(valid5), .inst_err(err5), .we(we), .waddr(waddr), .wdata(wdata));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0; pc = '0;
    ce0 = 1'b0; ce3 = 1'b0; ce5 = 1'b0;
    tick(); tick();
    chk("rst_inst", inst0, 32'h0);
    chk("rst_addr", addr0, 32'h0);
    chk("rst_valid", {31'b0, valid0}, 32'h0);
    chk("rst_err", {31'b0, err0}, 32'h0);
    chk("rst_stall0", {31'b0, stall0}, 32'h0);
    chk("rst_stall3", {31'b0, stall3}, 32'h0);

    wr(10'd0, 32'h34010001);
    wr(10'd1, 32'h34020002);
    wr(10'd2, 32'h11111111);
    rst = 1'b1;
    tick();

    // zero wait states, back-to-back fetches of pc 0 and 4
    ce0 = 1'b1; pc = 32'h0;
    tick();
    chk("w0_first_valid", {31'b0, valid0}, 32'h0);
    chk("w0_stall_a", {31'b0, stall0}, 32'h0);
    pc = 32'h4;
    tick();
    ce0 = 1'b0;
    chk("w0_valid_a", {31'b0, valid0}, 32'h1);
    chk("w0_inst_a", inst0, 32'h34010001);
    chk("w0_addr_a", addr0, 32'h0);
    chk("w0_stall_b", {31'b0, stall0}, 32'h0);
    tick();
    chk("w0_valid_b", {31'b0, valid0}, 32'h1);
    chk("w0_inst_b", inst0, 32'h34020002);
    chk("w0_addr_b", addr0, 32'h4);
    chk("w0_err_b", {31'b0, err0}, 32'h0);
    tick();
    chk("w0_valid_drop", {31'b0, valid0}, 32'h0);
    chk("w0_inst_hold", inst0, 32'h34020002);

    // misaligned pc 6
    ce0 = 1'b1; pc = 32'h6;
    tick();
    ce0 = 1'b0;
    tick();
    chk("mis_valid", {31'b0, valid0}, 32'h1);
    chk("mis_addr", addr0, 32'h6);
`ifdef INST_ROM_MISALIGN_CHK_EN
    chk("mis_inst", inst0, 32'h0);
    chk("mis_err", {31'b0, err0}, 32'h1);
`else
    chk("mis_inst", inst0, 32'h34020002);
    chk("mis_err", {31'b0, err0}, 32'h0);
`endif

    // out of range pc
    ce0 = 1'b1; pc = 32'h1000;
    tick();
    ce0 = 1'b0;
    chk("oor_early", {31'b0, valid0}, 32'h0);
    tick();
    chk("oor_valid", {31'b0, valid0}, 32'h1);
    chk("oor_inst", inst0, 32'h0);
    chk("oor_err", {31'b0, err0}, 32'h1);
    chk("oor_addr", addr0, 32'h1000);

    // same-edge write and fetch of word 2
    ce0 = 1'b1; pc = 32'h8; we = 1'b1; waddr = 10'd2; wdata = 32'hDEADBEEF;
    tick();
    we = 1'b0;
    tick();
    ce0 = 1'b0;
    chk("rbw_old", inst0, 32'h11111111);
    chk("rbw_err", {31'b0, err0}, 32'h0);
    tick();
    chk("rbw_new", inst0, 32'hDEADBEEF);
    chk("rbw_valid", {31'b0, valid0}, 32'h1);

    // three wait states, back-to-back accept in RESP
    ce3 = 1'b1; pc = 32'h8;
    tick();
    ce3 = 1'b0;
    chk("w3_stall_1", {31'b0, stall3}, 32'h1);
    chk("w3_valid_1", {31'b0, valid3}, 32'h0);
    tick();
    chk("w3_stall_2", {31'b0, stall3}, 32'h1);
    tick();
    chk("w3_stall_3", {31'b0, stall3}, 32'h1);
    chk("w3_valid_3", {31'b0, valid3}, 32'h0);
    tick();
    chk("w3_stall_resp", {31'b0, stall3}, 32'h0);
    chk("w3_valid_resp", {31'b0, valid3}, 32'h0);
    ce3 = 1'b1; pc = 32'h0;
    tick();
    ce3 = 1'b0;
    chk("w3_valid", {31'b0, valid3}, 32'h1);
    chk("w3_inst", inst3, 32'hDEADBEEF);
    chk("w3_addr", addr3, 32'h8);
    chk("w3_b2b_stall", {31'b0, stall3}, 32'h1);
    tick();
    chk("w3_b2b_stall2", {31'b0, stall3}, 32'h1);
    chk("w3_b2b_novalid", {31'b0, valid3}, 32'h0);
    tick();
    tick();
    chk("w3_b2b_stall_low", {31'b0, stall3}, 32'h0);
    tick();
    chk("w3_b2b_valid", {31'b0, valid3}, 32'h1);
    chk("w3_b2b_inst", inst3, 32'h34010001);
    chk("w3_b2b_addr", addr3, 32'h0);

    // five wait states: one full fetch, then reset during WAIT
    ce5 = 1'b1; pc = 32'h4;
    tick();
    ce5 = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("w5_pre_valid", {31'b0, valid5}, 32'h0);
    tick();
    chk("w5_valid", {31'b0, valid5}, 32'h1);
    chk("w5_inst", inst5, 32'h34020002);
    chk("w5_addr", addr5, 32'h4);
    ce5 = 1'b1; pc = 32'h0;
    tick();
    ce5 = 1'b0;
    tick(); tick();
    chk("w5_stall_wait", {31'b0, stall5}, 32'h1);
    rst = 1'b0;
    #1;
    chk("ares_stall", {31'b0, stall5}, 32'h0);
    chk("ares_inst", inst5, 32'h0);
    chk("ares_addr", addr5, 32'h0);
    chk("ares_valid", {31'b0, valid5}, 32'h0);
    chk("ares_inst0", inst0, 32'h0);
    tick();
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (valid5) seen++;
    end
    chk("ares_no_valid", seen, 0);
    ce5 = 1'b1; pc = 32'h8;
    tick();
    ce5 = 1'b0;
    chk("post_stall", {31'b0, stall5}, 32'h1);
    for (int i = 0; i < 5; i++) tick();
    chk("post_stall_low", {31'b0, stall5}, 32'h0);
    tick();
    chk("post_valid", {31'b0, valid5}, 32'h1);
    chk("post_inst", inst5, 32'hDEADBEEF);
    chk("post_addr", addr5, 32'h8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
